cpri_tx_pkg_buf: RTL

Single-clock, parametrised packet buffer and CPRI IQ transmit framer. It accepts typed payload packets on a sop/eop/valid stream and validates each packet's length against its type. It stores up to 2^SLOT_NUM_W complete packets in fixed-size RAM slots and replays each packet's payload, minus its header words, as a contiguous sop/eop-tagged burst when the CPRI IQ transmit side is enabled. It sits between the PUSCH dimension-reduction packer and the CPRI IQ mapper. Malformed or overflowing packets are dropped and counted instead of corrupting the stream.

---
 rtl/cpri_tx_pkg_buf_pkg.sv | 42 ++++
 rtl/cpri_tx_pkg_buf_if.sv | 21 ++
 rtl/sdp_ram_sync.sv | 24 ++
 rtl/cpri_tx_pkg_buf.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cpri_tx_pkg_buf_pkg.sv
// Shared types for the CPRI IQ transmit packet buffer: packet type codes,
// length table, FSM encodings and the readout pipeline tag.
package cpri_tx_pkg_buf_pkg;
  localparam int TYPE_W = 4;
  localparam int LEN_W  = 8;

  typedef enum logic [TYPE_W-1:0] {
    PT_T1 = 4'd1,
    PT_T2 = 4'd2,
    PT_T3 = 4'd3,
    PT_T4 = 4'd4
  } pkt_type_e;

  typedef struct packed {
    logic             ok;
    logic [LEN_W-1:0] len;
  } len_info_t;

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wr_st_e;
  typedef enum logic {R_IDLE, R_RUN} rd_st_e;

  typedef struct packed {
    logic vld;
    logic sop;
    logic eop;
  } ctl_t;

  // Total packet length (header included) for each known type.
  function automatic len_info_t type_len(input logic [TYPE_W-1:0] t);
    len_info_t r;
    r.ok  = 1'b1;
    r.len = '0;
    case (t)
      PT_T1:   r.len = 8'd56;
      PT_T2:   r.len = 8'd38;
      PT_T3:   r.len = 8'd86;
      PT_T4:   r.len = 8'd62;
      default: r.ok  = 1'b0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/cpri_tx_pkg_buf_if.sv
// Packet-in / IQ-out stream bundle of the transmit packet buffer.
interface cpri_tx_pkg_buf_if #(parameter int DATA_W = 64);
  logic              i_vld;
  logic              i_sop;
  logic              i_eop;
  logic [DATA_W-1:0] i_data;
  logic              i_iq_tx_enable;
  logic              o_iq_tx_valid;
  logic              o_iq_tx_sop;
  logic              o_iq_tx_eop;
  logic [DATA_W-1:0] o_iq_tx_data;

  modport slave (
    input  i_vld, i_sop, i_eop, i_data, i_iq_tx_enable,
    output o_iq_tx_valid, o_iq_tx_sop, o_iq_tx_eop, o_iq_tx_data
  );
  modport master (
    output i_vld, i_sop, i_eop, i_data, i_iq_tx_enable,
    input  o_iq_tx_valid, o_iq_tx_sop, o_iq_tx_eop, o_iq_tx_data
  );
endinterface

// File: rtl/sdp_ram_sync.sv
// Simple dual-port RAM; read data comes out RD_LAT cycles after the address.
module sdp_ram_sync #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 3
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0]              r_mem [2**ADDR_W];
  logic [RD_LAT:1][DATA_W-1:0]    r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_q[1] <= r_mem[i_raddr];
    for (int k = 2; k <= RD_LAT; k++) r_q[k] <= r_q[k-1];
  end

  assign o_rdata = r_q[RD_LAT];
endmodule

// File: rtl/cpri_tx_pkg_buf.sv
// Packet buffer + CPRI IQ framer: validates typed packets into fixed RAM slots
// and replays each payload (header stripped) as a contiguous sop/eop burst.
module cpri_tx_pkg_buf
  import cpri_tx_pkg_buf_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int SLOT_AW    = 7,
  parameter int SLOT_NUM_W = 3,
  parameter int HDR_WORDS  = 3,
  parameter int TYPE_WORD  = 2,
  parameter int TYPE_LSB   = 4,
  parameter int RD_LAT     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  cpri_tx_pkg_buf_if.slave      bus,
  output logic [SLOT_NUM_W:0]   o_free_size,
  output logic [15:0]           o_drop_cnt
);
  localparam int NSLOT = 2**SLOT_NUM_W;
  localparam int AW    = SLOT_NUM_W + SLOT_AW;
  localparam int LW    = SLOT_AW + 1;
  localparam int OW    = SLOT_NUM_W + 1;
  localparam logic [SLOT_AW-1:0] TW_IDX  = SLOT_AW'(TYPE_WORD);
  localparam logic [SLOT_AW-1:0] HDR_IDX = SLOT_AW'(HDR_WORDS);
  localparam logic [SLOT_AW-1:0] IDX_MAX = '1;
  localparam logic [LW-1:0]      HDR_LEN = LW'(HDR_WORDS);

  wr_st_e                r_wst, w_wst_n;
  rd_st_e                r_rdst, w_rdst_n;
  logic [SLOT_AW-1:0]    r_widx, w_idx, r_raddr, w_raddr_n;
  logic [LW-1:0]         r_wlen, w_wlen_n, w_tlen, r_rem, w_rem_n;
  logic [LW-1:0]         r_slot_len [NSLOT];
  logic [SLOT_NUM_W-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_inc;
  logic [OW-1:0]         r_occ, r_free;
  logic [15:0]           r_drop;
  logic                  w_take, w_drop, w_commit, w_tok, w_free, w_release;
  len_info_t             w_li;
  ctl_t                  w_ctl;
  ctl_t [RD_LAT:1]       r_vld_pipe;
  logic [DATA_W-1:0]     w_rdata;

  // Write side: every accepted word lands in the current slot; the slot is
  // only handed to the reader once the whole packet has been validated.
  always_comb begin
    w_li     = type_len(bus.i_data[TYPE_LSB +: TYPE_W]);
    w_free   = r_occ < OW'(NSLOT);
    w_wst_n  = r_wst;
    w_take   = 1'b0;
    w_drop   = 1'b0;
    w_commit = 1'b0;
    w_tok    = 1'b0;
    w_idx    = '0;
    w_wlen_n = r_wlen;
    w_tlen   = r_wlen;
    case (r_wst)
      W_IDLE: if (bus.i_vld && bus.i_sop) begin
        if (w_free) w_take = 1'b1;
        else begin
          w_drop  = 1'b1;
          w_wst_n = bus.i_eop ? W_IDLE : W_DROP;
        end
      end
      W_PKT: if (bus.i_vld) begin
        w_take = 1'b1;
        w_drop = bus.i_sop;
        w_idx  = bus.i_sop ? '0 : r_widx + 1'b1;
      end
      W_DROP: if (bus.i_vld && bus.i_eop) w_wst_n = W_IDLE;
      default: w_wst_n = W_IDLE;
    endcase
    if (w_take) begin
      w_wst_n = W_PKT;
      if (w_idx == TW_IDX) begin
        w_tok    = w_li.ok;
        w_tlen   = LW'(w_li.len);
        w_wlen_n = w_tlen;
      end else begin
        w_tok = w_idx > TW_IDX;
      end
      if (w_idx == TW_IDX && !w_li.ok) begin
        w_drop  = 1'b1;
        w_wst_n = bus.i_eop ? W_IDLE : W_DROP;
      end else if (bus.i_eop) begin
        if (w_tok && ({1'b0, w_idx} + 1'b1) == w_tlen) w_commit = 1'b1;
        else w_drop = 1'b1;
        w_wst_n = W_IDLE;
      end else if (w_idx == IDX_MAX) begin
        w_drop  = 1'b1;
        w_wst_n = W_DROP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wst    <= W_IDLE;
      r_widx   <= '0;
      r_wlen   <= '0;
      r_wr_ptr <= '0;
      r_drop   <= '0;
    end else begin
      r_wst  <= w_wst_n;
      r_wlen <= w_wlen_n;
      if (w_take) r_widx <= w_idx;
      if (w_commit) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_drop && r_drop != '1) r_drop <= r_drop + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) r_slot_len[r_wr_ptr] <= w_tlen;
  end

  // Read side: one read per cycle; enable matters only at a packet boundary,
  // and a queued packet follows the previous one with no gap.
  always_comb begin
    w_rd_ptr_inc = r_rd_ptr + 1'b1;
    w_rdst_n     = r_rdst;
    w_raddr_n    = r_raddr;
    w_rem_n      = r_rem;
    w_release    = 1'b0;
    w_ctl        = '0;
    case (r_rdst)
      R_IDLE: if (r_occ != '0 && bus.i_iq_tx_enable) begin
        w_rdst_n  = R_RUN;
        w_raddr_n = HDR_IDX;
        w_rem_n   = r_slot_len[r_rd_ptr] - HDR_LEN;
      end
      R_RUN: begin
        w_ctl.vld = 1'b1;
        w_ctl.sop = r_raddr == HDR_IDX;
        w_ctl.eop = r_rem == LW'(1);
        w_raddr_n = r_raddr + 1'b1;
        w_rem_n   = r_rem - 1'b1;
        if (w_ctl.eop) begin
          w_release = 1'b1;
          if (r_occ > OW'(1) && bus.i_iq_tx_enable) begin
            w_raddr_n = HDR_IDX;
            w_rem_n   = r_slot_len[w_rd_ptr_inc] - HDR_LEN;
          end else begin
            w_rdst_n = R_IDLE;
          end
        end
      end
      default: w_rdst_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdst     <= R_IDLE;
      r_raddr    <= '0;
      r_rem      <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_free     <= OW'(NSLOT);
      r_vld_pipe <= '0;
    end else begin
      r_rdst  <= w_rdst_n;
      r_raddr <= w_raddr_n;
      r_rem   <= w_rem_n;
      r_occ   <= r_occ + OW'(w_commit) - OW'(w_release);
      r_free  <= OW'(NSLOT) - r_occ;
      if (w_release) r_rd_ptr <= w_rd_ptr_inc;
      r_vld_pipe[1] <= w_ctl;
      for (int k = 2; k <= RD_LAT; k++) r_vld_pipe[k] <= r_vld_pipe[k-1];
    end
  end

  sdp_ram_sync #(.DATA_W(DATA_W), .ADDR_W(AW), .RD_LAT(RD_LAT)) u_ram (
    .clk     (clk),
    .i_we    (w_take),
    .i_waddr ({r_wr_ptr, w_idx}),
    .i_wdata (bus.i_data),
    .i_raddr ({r_rd_ptr, r_raddr}),
    .o_rdata (w_rdata)
  );

  assign bus.o_iq_tx_valid = r_vld_pipe[RD_LAT].vld;
  assign bus.o_iq_tx_sop   = r_vld_pipe[RD_LAT].sop;
  assign bus.o_iq_tx_eop   = r_vld_pipe[RD_LAT].eop;
  assign bus.o_iq_tx_data  = r_vld_pipe[RD_LAT].vld ? w_rdata : '0;
  assign o_free_size       = r_free;
  assign o_drop_cnt        = r_drop;
endmodule
